priority_encoder4: RTL and testbench



---
 rtl/penc4_pkg.sv | 12 +
 rtl/penc4_core.sv | 35 +++
 rtl/priority_encoder4.sv | 65 ++++++
 tb/tb_priority_encoder4.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/penc4_pkg.sv
// Shared types and constants for the 4-input priority encoder.
package penc4_pkg;

    typedef logic [1:0] penc_idx_t;

    localparam penc_idx_t IDX_A0    = 2'd0;
    localparam penc_idx_t IDX_A1    = 2'd1;
    localparam penc_idx_t IDX_A2    = 2'd2;
    localparam penc_idx_t IDX_A3    = 2'd3;
    localparam penc_idx_t IDX_RESET = IDX_A0;

endpackage

// File: rtl/penc4_core.sv
// Combinational priority scan over four request lines.
// Optional multi-active output is present when PENC4_MULTI_ERR_EN is defined.
module penc4_core
    import penc4_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic [3:0] req_i,
    output penc_idx_t  idx_o,
    output logic       any_o
`ifdef PENC4_MULTI_ERR_EN
    ,
    output logic       multi_o
`endif
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        idx_o = IDX_RESET;
        for (int unsigned i = 0; i < 4; i++) begin
            if (PRIO_MSB) begin
                if (req_i[i]) idx_o = penc_idx_t'(i);
            end else begin
                if (req_i[3 - i]) idx_o = penc_idx_t'(3 - i);
            end
        end
    end

    assign any_o = |req_i;

`ifdef PENC4_MULTI_ERR_EN
    assign multi_o = ($countones(req_i) > 1);
`endif

endmodule

// File: rtl/priority_encoder4.sv
// 4-input priority encoder with en-gated, asynchronously reset output registers.
// Define PENC4_MULTI_ERR_EN to add the registered 'multi' output.
module priority_encoder4
    import penc4_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    output logic y0,
    output logic y1,
    output logic valid
`ifdef PENC4_MULTI_ERR_EN
    ,
    output logic multi
`endif
);

    penc_idx_t idx_d, idx_q;
    logic      valid_d, valid_q;

`ifdef PENC4_MULTI_ERR_EN
    logic      multi_d, multi_q;
`endif

    penc4_core #(
        .PRIO_MSB (PRIO_MSB)
    ) u_core (
        .req_i   ({a3, a2, a1, a0}),
        .idx_o   (idx_d),
        .any_o   (valid_d)
`ifdef PENC4_MULTI_ERR_EN
        ,
        .multi_o (multi_d)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= IDX_RESET;
            valid_q <= 1'b0;
        end else if (en) begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

`ifdef PENC4_MULTI_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  multi_q <= 1'b0;
        else if (en) multi_q <= multi_d;
    end
    assign multi = multi_q;
`endif

    assign y0    = idx_q[0];
    assign y1    = idx_q[1];
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder4.sv
// Directed bench: two encoders (PRIO_MSB=1 and 0) share the same stimulus.
module tb_priority_encoder4;

    logic clk = 1'b0;
    logic rst_n, en, a0, a1, a2, a3;
    logic hy0, hy1, hvalid, ly0, ly1, lvalid;
`ifdef PENC4_MULTI_ERR_EN
    logic hmulti, lmulti;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    priority_encoder4 #(.PRIO_MSB(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .y0(hy0), .y1(hy1), .valid(hvalid)
`ifdef PENC4_MULTI_ERR_EN
        , .multi(hmulti)
`endif
    );

    priority_encoder4 #(.PRIO_MSB(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .y0(ly0), .y1(ly1), .valid(lvalid)
`ifdef PENC4_MULTI_ERR_EN
        , .multi(lmulti)
`endif
    );

    typedef struct {
        logic [3:0] req;
        logic [1:0] exp_h;
        logic [1:0] exp_l;
        logic       exp_valid;
        logic       exp_multi;
    } vec_t;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] eh, input logic [1:0] el,
                             input logic ev, input logic em);
        check({name, "/idx_h"}, {hy1, hy0}, eh);
        check({name, "/idx_l"}, {ly1, ly0}, el);
        check({name, "/valid_h"}, {1'b0, hvalid}, {1'b0, ev});
        check({name, "/valid_l"}, {1'b0, lvalid}, {1'b0, ev});
`ifdef PENC4_MULTI_ERR_EN
        check({name, "/multi_h"}, {1'b0, hmulti}, {1'b0, em});
        check({name, "/multi_l"}, {1'b0, lmulti}, {1'b0, em});
`else
        if (em === 1'bx) $display("unexpected x in expected multi");
`endif
    endtask

    task automatic drive(input logic [3:0] r);
        {a3, a2, a1, a0} = r;
    endtask

    // Inputs change 1 time unit after an edge; outputs sampled at the same point.
    task automatic step(input logic [3:0] r);
        drive(r);
        @(posedge clk);
        #1;
    endtask

    task automatic hold_seq(input string name, input logic [3:0] cap, input logic [1:0] eh,
                            input logic [1:0] el, input logic em);
        en = 1'b1;
        step(cap);
        check_all({name, "_cap"}, eh, el, 1'b1, em);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(4'b0001);
            check_all({name, "_hold"}, eh, el, 1'b1, em);
        end
        en = 1'b1;
        step(4'b0001);
        check_all({name, "_release"}, 2'b00, 2'b00, 1'b1, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{4'b0001, 2'b00, 2'b00, 1'b1, 1'b0},
            '{4'b0010, 2'b01, 2'b01, 1'b1, 1'b0},
            '{4'b0100, 2'b10, 2'b10, 1'b1, 1'b0},
            '{4'b1000, 2'b11, 2'b11, 1'b1, 1'b0},
            '{4'b1001, 2'b11, 2'b00, 1'b1, 1'b1},
            '{4'b0110, 2'b10, 2'b01, 1'b1, 1'b1},
            '{4'b0011, 2'b01, 2'b00, 1'b1, 1'b1},
            '{4'b1111, 2'b11, 2'b00, 1'b1, 1'b1},
            '{4'b0100, 2'b10, 2'b10, 1'b1, 1'b0},
            '{4'b0000, 2'b00, 2'b00, 1'b0, 1'b0},
            '{4'b1010, 2'b11, 2'b01, 1'b1, 1'b1},
            '{4'b1100, 2'b11, 2'b10, 1'b1, 1'b1},
            '{4'b0101, 2'b10, 2'b00, 1'b1, 1'b1}
        };

        rst_n = 1'b0;
        en    = 1'b1;
        drive(4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_state", 2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req);
            check_all($sformatf("vec%0d_%b", i, vecs[i].req),
                      vecs[i].exp_h, vecs[i].exp_l, vecs[i].exp_valid, vecs[i].exp_multi);
        end

        // Asynchronous reset between edges, then one idle edge after release.
        step(4'b1000);
        check_all("pre_reset", 2'b11, 2'b11, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_all("async_reset", 2'b00, 2'b00, 1'b0, 1'b0);
        drive(4'b0000);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset_idle", 2'b00, 2'b00, 1'b0, 1'b0);

        hold_seq("hold1000", 4'b1000, 2'b11, 2'b11, 1'b0);
        hold_seq("hold1010", 4'b1010, 2'b11, 2'b01, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
